// File: rtl/vector_mem_sequencer.sv
// Vector load/store sequencer: expands one issued vector memory op
// into VLEN element transfers with per-element handshake.
module vector_mem_sequencer #(
  parameter int VLEN   = 4,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              is_store,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [3:0]        base_reg,
  input  logic              flush,
  input  logic              mem_ack,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        reg_idx,
  output logic              rf_we,
  output logic [3:0]        elem_idx,
  output logic              stall,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] LAST = 4'(VLEN - 1);

  state_t            state;
  logic              is_store_q;
  logic [ADDR_W-1:0] base_addr_q;
  logic [3:0]        base_reg_q;
  logic [3:0]        idx;
  logic              in_req;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      is_store_q  <= 1'b0;
      base_addr_q <= '0;
      base_reg_q  <= '0;
      idx         <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          // flush in the issue cycle kills the op before it is accepted
          if (start && !flush) begin
            is_store_q  <= is_store;
            base_addr_q <= base_addr;
            base_reg_q  <= base_reg;
            idx         <= '0;
            state       <= REQ;
          end
        end
        REQ: begin
          if (flush) begin
            state <= IDLE;
          end else if (mem_ack) begin
            if (idx == LAST) begin
              state <= DONE;
            end else begin
              idx <= idx + 4'd1;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign in_req   = (state == REQ);
  assign busy     = (state != IDLE);
  assign stall    = busy | start;
  assign mem_req  = in_req;
  assign mem_we   = in_req & is_store_q;
  assign elem_idx = in_req ? idx : 4'd0;
  assign reg_idx  = in_req ? (base_reg_q + idx) : 4'd0;
  assign mem_addr = in_req
                  ? (base_addr_q + {{(ADDR_W-4){1'b0}}, idx})
                  : '0;
  // load data is written back in the ack cycle; flush cancels it
  assign rf_we    = in_req & mem_ack & ~is_store_q & ~flush;
  assign done     = (state == DONE) & ~flush;

endmodule

// File: tb/tb_vector_mem_sequencer.sv
// Scoreboard bench for vector_mem_sequencer: random and directed
// vector ops checked against an element-list reference model.
module tb_vector_mem_sequencer;

  localparam int VLEN = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        is_store = 1'b0;
  logic [31:0] base_addr = '0;
  logic [3:0]  base_reg = '0;
  logic        flush = 1'b0;
  logic        mem_ack = 1'b0;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  reg_idx;
  logic        rf_we;
  logic [3:0]  elem_idx;
  logic        stall;
  logic        busy;
  logic        done;

  vector_mem_sequencer #(.VLEN(VLEN), .ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .is_store(is_store),
    .base_addr(base_addr), .base_reg(base_reg), .flush(flush),
    .mem_ack(mem_ack), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .reg_idx(reg_idx), .rf_we(rf_we),
    .elem_idx(elem_idx), .stall(stall), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          op;
    bit          we;
    logic [31:0] addr;
    logic [3:0]  rg;
    logic [3:0]  ei;
  } rec_t;

  rec_t    sb[$];
  longint  done_q[$];
  longint  cyc = 0;
  int      checks = 0;
  int      errors = 0;
  int      op_id = 0;
  int      wt[VLEN];
  bit      exp_busy = 1'b0;
  bit      exp_stall = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h cyc=%0d", nm, act, exp, cyc);
    end
  endtask

  // Monitor: compares every presented request against the scoreboard
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        sb.delete();
        done_q.delete();
      end else begin
        chk("busy", busy, exp_busy);
        chk("stall", stall, exp_stall);
        if (mem_req) begin
          if (sb.size() == 0) begin
            chk("unexpected_req", mem_req, 1'b0);
          end else begin
            chk("mem_we", mem_we, sb[0].we);
            chk("mem_addr", mem_addr, sb[0].addr);
            chk("reg_idx", reg_idx, sb[0].rg);
            chk("elem_idx", elem_idx, sb[0].ei);
            chk("rf_we", rf_we, mem_ack && !sb[0].we && !flush);
            if (flush) begin
              int o;
              o = sb[0].op;
              while (sb.size() > 0 && sb[0].op == o)
                void'(sb.pop_front());
            end else if (mem_ack) begin
              void'(sb.pop_front());
            end
          end
        end else begin
          chk("rf_we_idle", rf_we, 1'b0);
        end
        if (done) begin
          if (done_q.size() == 0) begin
            chk("unexpected_done", done, 1'b0);
          end else begin
            chk("done_cycle", cyc, done_q.pop_front());
          end
        end
      end
    end
  end

  // fl_e/rs_e: element at which to flush (with ack) or reset; -1 = none
  task automatic run_op(input bit st, input logic [31:0] ba,
                        input logic [3:0] br, input int fl_e,
                        input int rs_e, input bit bs);
    longint c0;
    int     t;
    bit     cut;
    rec_t   r;
    @(posedge clk); #1;
    start = 1'b1;
    is_store = st;
    base_addr = ba;
    base_reg = br;
    exp_busy = 1'b0;
    exp_stall = 1'b1;
    c0 = cyc;
    t = 1;
    for (int e = 0; e < VLEN; e++) begin
      r.op = op_id;
      r.we = st;
      r.addr = ba + 32'(e);
      r.rg = br + 4'(e);
      r.ei = 4'(e);
      sb.push_back(r);
      t += wt[e] + 1;
    end
    if (fl_e < 0 && rs_e < 0) done_q.push_back(c0 + longint'(t));
    op_id++;
    @(posedge clk); #1;
    start = 1'b0;
    is_store = 1'($urandom);
    base_addr = $urandom;
    base_reg = 4'($urandom);
    exp_busy = 1'b1;
    cut = 1'b0;
    for (int e = 0; e < VLEN && !cut; e++) begin
      for (int k = 0; k <= wt[e]; k++) begin
        if (e == rs_e && k == 0) begin
          rst_n = 1'b0;
          #1;
          chk("rst_mem_req", mem_req, 1'b0);
          chk("rst_stall", stall, 1'b0);
          chk("rst_busy", busy, 1'b0);
          chk("rst_done", done, 1'b0);
          exp_busy = 1'b0;
          exp_stall = 1'b0;
          @(posedge clk); #1;
          rst_n = 1'b1;
          cut = 1'b1;
          break;
        end
        mem_ack = (k == wt[e]);
        flush = (e == fl_e) && (k == wt[e]);
        start = bs && (e == 1) && (k == 0);
        @(posedge clk); #1;
        start = 1'b0;
        mem_ack = 1'b0;
        if (flush) begin
          flush = 1'b0;
          exp_busy = 1'b0;
          exp_stall = 1'b0;
          cut = 1'b1;
          break;
        end
      end
    end
    if (!cut) begin
      @(posedge clk); #1;
      exp_busy = 1'b0;
      exp_stall = 1'b0;
    end
  endtask

  task automatic set_wait(input int w);
    for (int i = 0; i < VLEN; i++) wt[i] = w;
  endtask

  initial begin
    #2;
    chk("reset_req", mem_req, 1'b0);
    chk("reset_busy", busy, 1'b0);
    chk("reset_stall", stall, 1'b0);
    chk("reset_done", done, 1'b0);
    chk("reset_addr", mem_addr, 32'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);

    set_wait(0);
    run_op(1'b0, 32'h100, 4'd2, -1, -1, 1'b0);
    set_wait(2);
    run_op(1'b1, 32'h2000, 4'd7, -1, -1, 1'b0);
    set_wait(0);
    run_op(1'b0, 32'hFFFF_FFFE, 4'd14, -1, -1, 1'b0);
    set_wait(1);
    run_op(1'b0, 32'h40, 4'd3, -1, 2, 1'b0);
    set_wait(0);
    run_op(1'b0, 32'h300, 4'd9, 1, -1, 1'b1);
    run_op(1'b0, 32'h300, 4'd9, -1, -1, 1'b0);

    // flush in the issue cycle must reject the op
    @(posedge clk); #1;
    start = 1'b1;
    flush = 1'b1;
    exp_stall = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    flush = 1'b0;
    exp_stall = 1'b0;
    #1 chk("flush_idle_busy", busy, 1'b0);
    chk("flush_idle_req", mem_req, 1'b0);

    for (int n = 0; n < 40; n++) begin
      int fe;
      int re;
      logic [31:0] ba;
      for (int i = 0; i < VLEN; i++) wt[i] = $urandom_range(0, 2);
      fe = -1;
      re = -1;
      if ($urandom_range(0, 4) == 0) fe = $urandom_range(0, VLEN - 1);
      else if ($urandom_range(0, 9) == 0) re = $urandom_range(0, VLEN - 1);
      ba = $urandom;
      if ($urandom_range(0, 3) == 0) ba = 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
      run_op(1'($urandom), ba, 4'($urandom), fe, re, 1'($urandom));
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end

    repeat (3) @(posedge clk);
    #1;
    chk("sb_empty", 64'(sb.size()), 64'd0);
    chk("done_q_empty", 64'(done_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
